div32_seq: RTL and testbench

DIV32_SEQ -- requirements
Module: div32_seq

---
 rtl/div32_seq.sv | 152 +++++++++++++++
 tb/tb_div32_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/div32_seq.sv
// Sequential 32-bit divider, signed or unsigned.
// Uses restoring division on operand magnitudes, one quotient bit per cycle,
// then fixes up the signs. Divide-by-zero and the signed -2^31 / -1 case skip
// the iteration and report a fixed result one cycle after accept.
module div32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;         // partial remainder
  logic [31:0] quo_q, quo_d;         // dividend shifts out, quotient shifts in
  logic [31:0] dvs_q, dvs_d;         // divisor magnitude
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        div_zero_q, div_zero_d;
  logic        overflow_q, overflow_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted, diff;
  logic        ge;
  logic [31:0] rem_next, quo_next;

  // Operand magnitudes and one restoring step on a 33-bit partial remainder.
  always_comb begin
    a_neg    = is_signed & a[31];
    b_neg    = is_signed & b[31];
    a_mag    = a_neg ? (32'd0 - a) : a;
    b_mag    = b_neg ? (32'd0 - b) : b;
    shifted  = {rem_q, quo_q[31]};
    diff     = shifted - {1'b0, dvs_q};
    ge       = (shifted >= {1'b0, dvs_q});
    rem_next = ge ? diff[31:0] : shifted[31:0];
    quo_next = {quo_q[30:0], ge};
  end

  // Next-state logic: accept, iterate, hold result until consumed.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (b == 32'd0) begin
            quotient_d  = 32'hFFFF_FFFF;
            remainder_d = a;
            div_zero_d  = 1'b1;
            overflow_d  = 1'b0;
            state_d     = StDone;
          end else if (is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            quotient_d  = 32'h8000_0000;
            remainder_d = 32'd0;
            div_zero_d  = 1'b0;
            overflow_d  = 1'b1;
            state_d     = StDone;
          end else begin
            rem_d      = 32'd0;
            quo_d      = a_mag;
            dvs_d      = b_mag;
            negq_d     = a_neg ^ b_neg;
            negr_d     = a_neg;
            cnt_d      = 5'd0;
            div_zero_d = 1'b0;
            overflow_d = 1'b0;
            state_d    = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          // Final bit: publish the sign-corrected result directly.
          quotient_d  = negq_q ? (32'd0 - quo_next) : quo_next;
          remainder_d = negr_q ? (32'd0 - rem_next) : rem_next;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 5'd0;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      dvs_q       <= 32'd0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
    end
  end

  // Handshake outputs decode straight from state.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    quotient  = quotient_q;
    remainder = remainder_q;
    div_zero  = div_zero_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_div32_seq.sv
// Directed self-checking bench for div32_seq.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, is_signed, out_valid, out_ready;
  logic [31:0] a, b, quotient, remainder;
  logic        div_zero, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  div32_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Issue one request from IDLE and wait (bounded) for out_valid.
  // lat counts edges after the accept edge until out_valid is seen.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                       input bit scramble, output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output logic ov, output int lat);
    in_valid = 1'b1; a = av; b = bv; is_signed = sv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (scramble) begin
        in_valid  = 1'($urandom_range(0, 1));
        a         = $urandom;
        b         = $urandom;
        is_signed = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    q = quotient; r = remainder; dz = div_zero; ov = overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_checks++; if ({quotient, remainder, div_zero, overflow} !== 66'd0) begin
      n_fail++; $display("FAIL reset outputs: got q=%h r=%h dz=%b ov=%b want all 0",
                         quotient, remainder, div_zero, overflow);
    end
  endtask

  task automatic test_unsigned_basic();
    logic [31:0] q, r; logic dz, ov; int lat;
    do_op(32'd100, 32'd7, 1'b0, 1'b0, q, r, dz, ov, lat);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL u100/7 latency: got %0d want 32", lat); end
    n_checks++; if (q !== 32'd14) begin n_fail++; $display("FAIL u100/7 quotient: got %h want %h", q, 32'd14); end
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL u100/7 remainder: got %h want %h", r, 32'd2); end
    n_checks++; if ({dz, ov} !== 2'b00) begin n_fail++; $display("FAIL u100/7 flags: got %b%b want 00", dz, ov); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL u100/7 in_ready in DONE: got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL u100/7 in_ready after: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL u100/7 out_valid after: got %b want 0", out_valid); end
  endtask

  task automatic test_signed();
    logic [31:0] q, r; logic dz, ov; int lat;
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, q, r, dz, ov, lat);
    n_checks++; if (q !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL s-7/2 quotient: got %h want FFFFFFFD", q); end
    n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL s-7/2 remainder: got %h want FFFFFFFF", r); end
    @(posedge clk); #1;
    do_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, q, r, dz, ov, lat);
    n_checks++; if (q !== 32'h7FFF_FFFC) begin n_fail++; $display("FAIL uFFFFFFF9/2 quotient: got %h want 7FFFFFFC", q); end
    n_checks++; if (r !== 32'd1) begin n_fail++; $display("FAIL uFFFFFFF9/2 remainder: got %h want 1", r); end
    @(posedge clk); #1;
    do_op(32'd1000, 32'hFFFF_FFFD, 1'b1, 1'b0, q, r, dz, ov, lat);
    n_checks++; if ({q, r} !== {32'hFFFF_FEB3, 32'd1}) begin
      n_fail++; $display("FAIL s1000/-3: got q=%h r=%h want q=FFFFFEB3 r=1", q, r);
    end
    @(posedge clk); #1;
    do_op(32'hFFFF_FC18, 32'hFFFF_FFFD, 1'b1, 1'b0, q, r, dz, ov, lat);
    n_checks++; if ({q, r} !== {32'd333, 32'hFFFF_FFFF}) begin
      n_fail++; $display("FAIL s-1000/-3: got q=%h r=%h want q=14D r=FFFFFFFF", q, r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r; logic dz, ov; int lat;
    for (int s = 0; s < 2; s++) begin
      do_op(32'd5, 32'd0, 1'(s), 1'b0, q, r, dz, ov, lat);
      n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL divzero s=%0d latency: got %0d want 0", s, lat); end
      n_checks++; if ({q, r, dz, ov} !== {32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL divzero s=%0d: got q=%h r=%h dz=%b ov=%b want q=FFFFFFFF r=5 dz=1 ov=0",
                           s, q, r, dz, ov);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] q, r; logic dz, ov; int lat;
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, q, r, dz, ov, lat);
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL overflow latency: got %0d want 0", lat); end
    n_checks++; if ({q, r, dz, ov} !== {32'h8000_0000, 32'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL overflow: got q=%h r=%h dz=%b ov=%b want q=80000000 r=0 dz=0 ov=1",
                         q, r, dz, ov);
    end
    @(posedge clk); #1;
    // Same operands unsigned is an ordinary division.
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, q, r, dz, ov, lat);
    n_checks++; if ({q, r, dz, ov} !== {32'd0, 32'h8000_0000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL u80000000/FFFFFFFF: got q=%h r=%h dz=%b ov=%b want q=0 r=80000000 flags 0",
                         q, r, dz, ov);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_edges();
    logic [31:0] q, r; logic dz, ov; int lat;
    do_op(32'd0, 32'd9, 1'b1, 1'b0, q, r, dz, ov, lat);
    n_checks++; if ({q, r, lat} !== {32'd0, 32'd0, 32'd32}) begin
      n_fail++; $display("FAIL zero dividend: got q=%h r=%h lat=%0d want 0 0 32", q, r, lat);
    end
    @(posedge clk); #1;
    do_op(32'hFFFF_FFFD, 32'd10, 1'b1, 1'b0, q, r, dz, ov, lat);
    n_checks++; if ({q, r} !== {32'd0, 32'hFFFF_FFFD}) begin
      n_fail++; $display("FAIL s-3/10: got q=%h r=%h want q=0 r=FFFFFFFD", q, r);
    end
    @(posedge clk); #1;
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, q, r, dz, ov, lat);
    n_checks++; if ({q, r} !== {32'hFFFF_FFFF, 32'd0}) begin
      n_fail++; $display("FAIL uFFFFFFFF/1: got q=%h r=%h want q=FFFFFFFF r=0", q, r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] q, r; logic dz, ov; int lat;
    int bad;
    out_ready = 1'b0;
    do_op(32'd50000, 32'd123, 1'b0, 1'b1, q, r, dz, ov, lat);
    n_checks++; if ({q, r, lat} !== {32'd406, 32'd62, 32'd32}) begin
      n_fail++; $display("FAIL scrambled 50000/123: got q=%h r=%h lat=%0d want q=196 r=3E lat=32", q, r, lat);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 32'd406 ||
          remainder !== 32'd62 || div_zero !== 1'b0 || overflow !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL backpressure hold: got %0d bad cycles want 0", bad); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL backpressure release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, r; logic dz, ov; int lat;
    int seen;
    in_valid = 1'b1; a = 32'd1000; b = 32'd3; is_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    n_checks++; if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL mid reset: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid reset stray result: got %0d valid cycles want 0", seen); end
    do_op(32'd9, 32'd3, 1'b0, 1'b0, q, r, dz, ov, lat);
    n_checks++; if ({q, r, lat} !== {32'd3, 32'd0, 32'd32}) begin
      n_fail++; $display("FAIL after reset 9/3: got q=%h r=%h lat=%0d want 3 0 32", q, r, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, r; logic dz, ov; int lat;
    do_op(32'd77, 32'd8, 1'b0, 1'b0, q, r, dz, ov, lat);
    n_checks++; if ({q, r} !== {32'd9, 32'd5}) begin
      n_fail++; $display("FAIL b2b first 77/8: got q=%h r=%h want 9 5", q, r);
    end
    @(posedge clk); #1;
    do_op(32'd5, 32'd0, 1'b0, 1'b0, q, r, dz, ov, lat);
    n_checks++; if ({q, r, dz, lat} !== {32'hFFFF_FFFF, 32'd5, 1'b1, 32'd0}) begin
      n_fail++; $display("FAIL b2b divzero: got q=%h r=%h dz=%b lat=%0d want FFFFFFFF 5 1 0", q, r, dz, lat);
    end
    @(posedge clk); #1;
    do_op(32'd12345, 32'd100, 1'b1, 1'b0, q, r, dz, ov, lat);
    n_checks++; if ({q, r, dz, ov} !== {32'd123, 32'd45, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL b2b 12345/100: got q=%h r=%h dz=%b ov=%b want 7B 2D 0 0", q, r, dz, ov);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_edges();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
